// File: rtl/gmii_tx_framer_pkg.sv
// Shared types and constants for the GMII transmit framer and its CRC step.
package gmii_tx_framer_pkg;

  localparam int unsigned BCNT_W = 16;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DRAIN
  } state_e;

  // Show-ahead FIFO head word: end-of-frame flag above the data byte.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

endpackage

// File: rtl/gmii_tx_framer_crc.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB-first bit order).
module crc32_d8
  import gmii_tx_framer_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  always_comb begin
    crc_next_c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_next_c = crc_next_c[0] ? ((crc_next_c >> 1) ^ CRC32_POLY) : (crc_next_c >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// Frames FIFO bytes for GMII: preamble/SFD, zero padding, FCS and inter-frame gap.
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int unsigned PRE_LEN     = 7,
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned IFG_LEN     = 12
) (
  input  logic       gmii_gtx_clk,
  input  logic       sys_rst,
  input  logic       frm_rdy,
  input  logic       rd_empty,
  input  logic [8:0] rd_data,
  output logic       rd_en,
  output logic       fifo_dv,
  output logic [7:0] fifo_din,
  output logic       underrun
);

  localparam int unsigned PI_MAX   = (PRE_LEN > IFG_LEN) ? PRE_LEN : IFG_LEN;
  localparam int unsigned CNT_MAX  = (PI_MAX > 3) ? PI_MAX : 3;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IFG_LAST = (IFG_LEN > 0) ? IFG_LEN - 1 : 0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [31:0]         crc_q, crc_d, crc_next_c, fcs_word;
  logic                dv_q, dv_d, underrun_q, underrun_d;
  logic [7:0]          din_q, din_d, crc_byte;
  fifo_word_t          word;

  assign word         = fifo_word_t'(rd_data);
  assign fcs_word     = ~crc_q;
  assign byte_cnt_inc = (byte_cnt_q == {BCNT_W{1'b1}}) ? byte_cnt_q : byte_cnt_q + BCNT_W'(1);

  crc32_d8 u_crc (
    .crc        (crc_q),
    .data       (crc_byte),
    .crc_next_c (crc_next_c)
  );

  // Next-state, pop strobe and next output byte.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    dv_d       = 1'b0;
    din_d      = 8'h00;
    underrun_d = 1'b0;
    rd_en      = 1'b0;
    crc_byte   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (frm_rdy) begin
          dv_d    = 1'b1;
          din_d   = PREAMBLE_BYTE;
          cnt_d   = CNT_W'(1);
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        dv_d = 1'b1;
        if (cnt_q < CNT_W'(PRE_LEN)) begin
          din_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          din_d      = SFD_BYTE;
          cnt_d      = '0;
          byte_cnt_d = '0;
          crc_d      = CRC32_INIT;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rd_empty) begin
          underrun_d = 1'b1;
          state_d    = ST_DRAIN;
        end else begin
          rd_en      = 1'b1;
          dv_d       = 1'b1;
          din_d      = word.data;
          crc_byte   = word.data;
          crc_d      = crc_next_c;
          byte_cnt_d = byte_cnt_inc;
          if (word.last) begin
            cnt_d   = '0;
            state_d = (byte_cnt_inc < BCNT_W'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
          end
        end
      end
      ST_PAD: begin
        dv_d       = 1'b1;
        crc_d      = crc_next_c;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc >= BCNT_W'(MIN_PAYLOAD)) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        dv_d  = 1'b1;
        din_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IFG: begin
        if (cnt_q >= CNT_W'(IFG_LAST)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!rd_empty) begin
          rd_en = 1'b1;
          if (word.last) begin
            cnt_d   = '0;
            state_d = ST_IFG;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_gtx_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC32_INIT;
      dv_q       <= 1'b0;
      din_q      <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      dv_q       <= dv_d;
      din_q      <= din_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo_dv  = dv_q;
  assign fifo_din = din_q;
  assign underrun = underrun_q;

endmodule
